// File: rtl/div_seq_pkg.sv
// Shared constants, state encoding and helpers for the sequential divider.
package div_seq_pkg;

    localparam int unsigned REG_W      = 32;
    localparam int unsigned DREG_W     = 64;
    localparam int unsigned WORK_W     = 65;
    localparam int unsigned CNT_W      = 6;
    localparam int unsigned ITERATIONS = 32;

    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;
    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;

    typedef enum logic [1:0] {
        DIV_FREE   = 2'b00,
        DIV_BYZERO = 2'b01,
        DIV_ON     = 2'b10,
        DIV_END    = 2'b11
    } div_state_e;

    // Two's-complement magnitude of a negative operand when dividing signed.
    function automatic logic [REG_W-1:0] abs_val(input logic sgn, input logic [REG_W-1:0] x);
        return (sgn && x[REG_W-1]) ? (~x + REG_W'(1)) : x;
    endfunction

endpackage

// File: rtl/div_seq.sv
// Radix-2 restoring divider, 32 iterations, for DIV/DIVU with annul and
// divide-by-zero shortcut. result_o = {remainder, quotient}.
module div_seq
    import div_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              signed_div_i,
    input  logic [REG_W-1:0]  opdata1_i,
    input  logic [REG_W-1:0]  opdata2_i,
    input  logic              start_i,
    input  logic              annul_i,
    output logic [DREG_W-1:0] result_o,
    output logic              ready_o,
    output logic              busy_o
);

    div_state_e          r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [WORK_W-1:0]   r_work;
    logic [REG_W-1:0]    r_divisor;
    logic                r_neg_q;
    logic                r_neg_r;

    logic                w_req;
    logic [REG_W:0]      w_diff;
    logic [REG_W-1:0]    w_quot;
    logic [REG_W-1:0]    w_rem;

    assign w_req  = (start_i == DIV_START) && !annul_i;
    assign w_diff = {1'b0, r_work[63:32]} - {1'b0, r_divisor};

    // Sign fix-up applied to the finished magnitudes.
    assign w_quot = r_neg_q ? (~r_work[31:0]  + REG_W'(1)) : r_work[31:0];
    assign w_rem  = r_neg_r ? (~r_work[64:33] + REG_W'(1)) : r_work[64:33];

    // Stall starts in the request cycle so ex never advances past a divide.
    assign busy_o = (r_state == DIV_BYZERO) || (r_state == DIV_ON) ||
                    ((r_state == DIV_FREE) && w_req);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= DIV_FREE;
            r_cnt     <= '0;
            r_work    <= '0;
            r_divisor <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            ready_o   <= DIV_RESULT_NOT_READY;
            result_o  <= '0;
        end else begin
            case (r_state)
                DIV_FREE: begin
                    if (w_req) begin
                        if (opdata2_i == '0) begin
                            r_state <= DIV_BYZERO;
                        end else begin
                            r_state   <= DIV_ON;
                            r_cnt     <= '0;
                            r_work    <= {32'b0, abs_val(signed_div_i, opdata1_i), 1'b0};
                            r_divisor <= abs_val(signed_div_i, opdata2_i);
                            r_neg_q   <= signed_div_i && (opdata1_i[REG_W-1] ^ opdata2_i[REG_W-1]);
                            r_neg_r   <= signed_div_i && opdata1_i[REG_W-1];
                        end
                    end
                end
                DIV_BYZERO: begin
                    if (annul_i) begin
                        r_state <= DIV_FREE;
                    end else begin
                        r_state <= DIV_END;
                        r_work  <= '0;
                        r_neg_q <= 1'b0;
                        r_neg_r <= 1'b0;
                    end
                end
                DIV_ON: begin
                    if (annul_i) begin
                        r_state <= DIV_FREE;
                        r_cnt   <= '0;
                    end else begin
                        // Restore on borrow, otherwise keep the difference and shift in a 1.
                        if (w_diff[REG_W]) begin
                            r_work <= {r_work[63:0], 1'b0};
                        end else begin
                            r_work <= {w_diff[31:0], r_work[31:0], 1'b1};
                        end
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (r_cnt == CNT_W'(ITERATIONS - 1)) begin
                            r_state <= DIV_END;
                        end
                    end
                end
                DIV_END: begin
                    if (start_i == DIV_STOP) begin
                        r_state  <= DIV_FREE;
                        ready_o  <= DIV_RESULT_NOT_READY;
                        result_o <= '0;
                    end else begin
                        ready_o  <= DIV_RESULT_READY;
                        result_o <= {w_rem, w_quot};
                    end
                end
                default: r_state <= DIV_FREE;
            endcase
        end
    end

endmodule
